// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: picks sequential/branch/jump/exception
// target for the PC register and buffers redirects that arrive while a fetch is pending.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic        flush,
  output logic [31:0] epc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            pend_valid, pend_valid_next;
  logic            pend_exc, pend_exc_next;
  logic [XLEN-1:0] pend_target, pend_target_next;
  logic [XLEN-1:0] epc_next;
  logic            flush_next;
  logic            fetch_req_next;
  logic            accept;
  logic            redirect;

  assign accept = (state == FETCH) && fetch_ack && !stall;

  // Next-state, next-PC selection and pending-redirect buffer
  always_comb begin
    state_next       = state;
    pc_d             = pc_q;
    flush_next       = 1'b0;
    epc_next         = epc;
    pend_valid_next  = pend_valid;
    pend_exc_next    = pend_exc;
    pend_target_next = pend_target;
    redirect         = 1'b0;

    case (state)
      IDLE: begin
        pc_d       = RESET_VECTOR;
        state_next = FETCH;
      end
      FETCH: begin
        if (accept) begin
          redirect = 1'b1;
          if (exception) begin
            pc_d     = EXC_VECTOR;
            epc_next = pc_q;
          end else if (pend_valid) begin
            pc_d = pend_target;
          end else if (jump) begin
            pc_d = jump_target;
          end else if (branch_taken) begin
            pc_d = branch_target;
          end else begin
            pc_d     = pc_q + PC_STEP;
            redirect = 1'b0;
          end
          pend_valid_next = 1'b0;
          pend_exc_next   = 1'b0;
          flush_next      = redirect;
          if (redirect) begin
            state_next = REDIR;
          end
        end
      end
      REDIR: begin
        state_next = FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // An exception locks the buffer against later jumps/branches until it is taken
    if (!accept) begin
      if (exception) begin
        pend_valid_next  = 1'b1;
        pend_exc_next    = 1'b1;
        pend_target_next = EXC_VECTOR;
        epc_next         = pc_q;
      end else if (!pend_exc && jump) begin
        pend_valid_next  = 1'b1;
        pend_target_next = jump_target;
      end else if (!pend_exc && branch_taken) begin
        pend_valid_next  = 1'b1;
        pend_target_next = branch_target;
      end
    end

    fetch_req_next = (state_next == FETCH);

    if (reset) begin
      pc_d = RESET_VECTOR;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_req   <= 1'b0;
      flush       <= 1'b0;
      epc         <= '0;
      pend_valid  <= 1'b0;
      pend_exc    <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_next;
      fetch_req   <= fetch_req_next;
      flush       <= flush_next;
      epc         <= epc_next;
      pend_valid  <= pend_valid_next;
      pend_exc    <= pend_exc_next;
      pend_target <= pend_target_next;
    end
  end

endmodule
